// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - arb_state_e : FSM state encoding (IDLE, HDR, SEND, WAIT_HI, WAIT_LO)
//   - BYTE_W      : width of one transmitted byte
//   - rr_pick()   : rotate-priority pick returning a one-hot winner (up to 8 requesters)
package uart_tx_arb_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StHdr    = 3'd1,
        StSend   = 3'd2,
        StWaitHi = 3'd3,
        StWaitLo = 3'd4
    } arb_state_e;

    // First set bit of valid searching upward from ptr+1, wrapping at n.
    // Bits at or above n are never returned.
    function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                           input logic [3:0] n);
        logic [7:0] pick;
        logic       found;
        logic [2:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (n != 4'd0 && k <= int'(n)) begin
                idx = 3'((int'(ptr) + k) % int'(n));
                if (!found && valid[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder.
//   i_valid : per-requester request bits
//   i_ptr   : index of the previous winner; search starts at i_ptr+1
//   o_grant : one-hot winner, zero when nothing is valid
module rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [2:0]       i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    logic [7:0] w_valid_ext;
    logic [7:0] w_pick;
    logic       w_unused_pick;

    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[N_REQ-1:0]   = i_valid;
    end

    assign w_pick        = rr_pick(w_valid_ext, i_ptr, 4'(N_REQ));
    assign o_grant       = w_pick[N_REQ-1:0];
    // Upper bits are always zero for N_REQ < 8.
    assign w_unused_pick = ^w_pick;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter among N_REQ byte streams.
// A winner keeps the transmitter until it sends a byte flagged last or stalls for STALL_CYCLES.
// Optional build macro UART_TX_ARB_HEADER_EN: each grant first sends {HDR_TAG, index}.
// Ports:
//   Clk_100M, Reset  : clock and synchronous active-high reset
//   req_valid/data/last : per-requester byte offer (data packed 8 bits per requester)
//   req_ack          : one-cycle pulse when a requester's byte is taken
//   grant            : one-hot current owner, zero when idle
//   stall_abort      : one-cycle pulse when a grant is revoked by timeout
//   Tx_Data/Tx_Send  : byte and send strobe to UART_Sender
//   Tx_Busy          : UART_Sender busy status
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter logic [15:0] STALL_CYCLES = 16'd50000,
    parameter logic [4:0]  HDR_TAG      = 5'h15
) (
    input  logic                      Clk_100M,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ack,
    output logic [N_REQ-1:0]          grant,
    output logic                      stall_abort,
    output logic [BYTE_W-1:0]         Tx_Data,
    output logic                      Tx_Send,
    input  logic                      Tx_Busy
);

    localparam logic [15:0] StallLimit = STALL_CYCLES - 16'd1;

    arb_state_e          r_state, w_state_d;
    logic [N_REQ-1:0]    r_grant, w_grant_d;
    logic [2:0]          r_gidx, w_gidx_d;
    logic [2:0]          r_ptr, w_ptr_d;
    logic                r_last, w_last_d;
    logic [15:0]         r_cnt, w_cnt_d;
    logic [BYTE_W-1:0]   r_tx_data, w_tx_data_d;
    logic                r_tx_send, w_tx_send_d;
    logic [N_REQ-1:0]    r_ack, w_ack_d;
    logic                r_abort, w_abort_d;

    logic [N_REQ-1:0]    w_pick;
    logic [2:0]          w_pick_idx;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [BYTE_W-1:0]   w_sel_data;
    logic [BYTE_W-1:0]   w_hdr_byte;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    // Index of the one-hot pick, and the owner's request selected by the one-hot grant.
    always_comb begin
        w_pick_idx  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_pick[i]) begin
                w_pick_idx = 3'(i);
            end
            if (r_grant[i]) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign w_hdr_byte = {HDR_TAG, r_gidx};

`ifndef UART_TX_ARB_HEADER_EN
    logic w_unused_hdr;
    assign w_unused_hdr = ^w_hdr_byte;
`endif

    // State register
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_last    <= 1'b0;
            r_cnt     <= '0;
            r_tx_data <= '0;
            r_tx_send <= 1'b0;
            r_ack     <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_grant   <= w_grant_d;
            r_gidx    <= w_gidx_d;
            r_ptr     <= w_ptr_d;
            r_last    <= w_last_d;
            r_cnt     <= w_cnt_d;
            r_tx_data <= w_tx_data_d;
            r_tx_send <= w_tx_send_d;
            r_ack     <= w_ack_d;
            r_abort   <= w_abort_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d   = r_state;
        w_grant_d   = r_grant;
        w_gidx_d    = r_gidx;
        w_ptr_d     = r_ptr;
        w_last_d    = r_last;
        w_cnt_d     = r_cnt;
        w_tx_data_d = r_tx_data;
        w_tx_send_d = 1'b0;
        w_ack_d     = '0;
        w_abort_d   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|req_valid) begin
                    w_grant_d = w_pick;
                    w_gidx_d  = w_pick_idx;
                    w_cnt_d   = '0;
`ifdef UART_TX_ARB_HEADER_EN
                    w_state_d = StHdr;
`else
                    w_state_d = StSend;
`endif
                end
            end
`ifdef UART_TX_ARB_HEADER_EN
            StHdr: begin
                if (!Tx_Busy) begin
                    w_tx_data_d = w_hdr_byte;
                    w_tx_send_d = 1'b1;
                    w_last_d    = 1'b0;
                    w_state_d   = StWaitHi;
                end
            end
`endif
            StSend: begin
                if (w_sel_valid && !Tx_Busy) begin
                    w_tx_data_d = w_sel_data;
                    w_tx_send_d = 1'b1;
                    w_ack_d     = r_grant;
                    w_last_d    = w_sel_last;
                    w_cnt_d     = '0;
                    w_state_d   = StWaitHi;
                end else if (!w_sel_valid) begin
                    if (r_cnt >= StallLimit) begin
                        w_abort_d = 1'b1;
                        w_grant_d = '0;
                        w_ptr_d   = r_gidx;
                        w_cnt_d   = '0;
                        w_state_d = StIdle;
                    end else if (r_cnt != 16'hFFFF) begin
                        w_cnt_d = r_cnt + 16'd1;
                    end
                end
            end
            StWaitHi: begin
                // Keep the strobe up until the sender acknowledges by going busy.
                if (Tx_Busy) begin
                    w_state_d = StWaitLo;
                end else begin
                    w_tx_send_d = 1'b1;
                end
            end
            StWaitLo: begin
                if (!Tx_Busy) begin
                    if (r_last) begin
                        w_grant_d = '0;
                        w_ptr_d   = r_gidx;
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StSend;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs (all registered)
    always_comb begin
        Tx_Data     = r_tx_data;
        Tx_Send     = r_tx_send;
        req_ack     = r_ack;
        grant       = r_grant;
        stall_abort = r_abort;
    end

endmodule
